// File: rtl/watch_core.sv
// watch_core -- BCD time-of-day counter with run/stop control and a 12/24-hour display.
//
// Ports
//   clk           single clock, all state changes on the rising edge
//   reset         asynchronous active-low reset
//   start_resume  level request to run (ignored when stop is also high)
//   stop          level request to halt (wins over start_resume)
//   clear         synchronous clear of time and prescaler (FSM state kept)
//   mode_24h      display format: 1 = 24-hour, 0 = 12-hour
//   set_load      one-cycle strobe that loads set_time when it is a valid time
//   set_time      BCD {hr1,hr0,min1,min0,sec1,sec0}, hours in 24-hour form
//   hr1..sec0     registered BCD display digits
//   pm            1 when the internal hour is 12..23
//   running       1 while the FSM is in RUNNING
//   daypass       one-cycle pulse when 23:59:59 rolls over to 00:00:00
//   set_err       one-cycle pulse after a rejected set_load (or alarm_load)
//
// Optional feature, macro WATCH_ALARM_EN: adds alarm_time (BCD hh:mm, 24-hour form),
// alarm_load, alarm_arm and alarm_hit. alarm_hit pulses when a counting tick brings the
// time to hh:mm:00 of the stored alarm while alarm_arm is high.
//
// Parameters
//   TICK_DIV     clk cycles per one-second tick (1..2^24)
//   DEFAULT_24H  mode the integration ties mode_24h to; selects the hour digits shown
//                while reset is asserted (00 for 24-hour, 12 for 12-hour)

module watch_core #(
  parameter int unsigned TICK_DIV    = 1,
  parameter bit          DEFAULT_24H = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_resume,
  input  logic        stop,
  input  logic        clear,
  input  logic        mode_24h,
  input  logic        set_load,
  input  logic [23:0] set_time,
`ifdef WATCH_ALARM_EN
  input  logic [15:0] alarm_time,
  input  logic        alarm_load,
  input  logic        alarm_arm,
  output logic        alarm_hit,
`endif
  output logic [3:0]  hr1,
  output logic [3:0]  hr0,
  output logic [3:0]  min1,
  output logic [3:0]  min0,
  output logic [3:0]  sec1,
  output logic [3:0]  sec0,
  output logic        pm,
  output logic        running,
  output logic        daypass,
  output logic        set_err
);

  localparam logic [0:0]  ST_STOPPED = 1'b0;
  localparam logic [0:0]  ST_RUNNING = 1'b1;
  localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 32'd1);
  // Hour digits shown during reset depend on the mode the block is integrated in.
  localparam logic [7:0]  HR_RESET   = DEFAULT_24H ? 8'h00 : 8'h12;

  // A BCD hour pair is valid for 00..23.
  function automatic logic hour_bcd_ok(input logic [3:0] tens, input logic [3:0] ones);
    logic ok;
    if (tens < 4'd2) begin
      ok = (ones <= 4'd9);
    end else if (tens == 4'd2) begin
      ok = (ones <= 4'd3);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Full hh:mm:ss BCD validity check.
  function automatic logic time_bcd_ok(input logic [23:0] t);
    return hour_bcd_ok(t[23:20], t[19:16]) && (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
           (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  // Converts a (validated) BCD hour pair to the internal binary hour.
  function automatic logic [4:0] bcd_hour_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] v;
    v = ({4'd0, tens} * 8'd10) + {4'd0, ones};
    return v[4:0];
  endfunction

  // Maps the internal 0..23 hour onto the displayed BCD pair for the selected format.
  function automatic logic [7:0] hour_display(input logic [4:0] h, input logic is_24h);
    logic [4:0] v;
    logic [7:0] d;
    if (is_24h) begin
      v = h;
    end else if (h == 5'd0) begin
      v = 5'd12;
    end else if (h > 5'd12) begin
      v = h - 5'd12;
    end else begin
      v = h;
    end
    if (v >= 5'd20) begin
      d = {4'd2, 4'(v - 5'd20)};
    end else if (v >= 5'd10) begin
      d = {4'd1, 4'(v - 5'd10)};
    end else begin
      d = {4'd0, v[3:0]};
    end
    return d;
  endfunction

  logic [0:0]  state_r;
  logic [0:0]  state_nxt_s;
  logic [23:0] presc_r;
  logic [23:0] presc_step_s;
  logic [23:0] presc_nxt_s;
  logic [3:0]  sec0_r, sec1_r, min0_r, min1_r;
  logic [3:0]  sec0_nxt_s, sec1_nxt_s, min0_nxt_s, min1_nxt_s;
  logic [4:0]  hour_r;
  logic [4:0]  hour_nxt_s;
  logic [3:0]  hr1_r, hr0_r;
  logic        pm_r;
  logic        daypass_r;
  logic        set_err_r;
  logic        tick_s;
  logic        tick_taken_s;
  logic        rollover_s;
  logic        load_err_s;
  logic        alarm_err_s;
  logic [7:0]  hr_disp_s;

  assign tick_s = (state_r == ST_RUNNING) && (presc_r == PRESC_LAST);

  // Run/stop FSM next state; stop dominates start_resume.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_STOPPED: begin
        if (start_resume && !stop) begin
          state_nxt_s = ST_RUNNING;
        end else begin
          state_nxt_s = ST_STOPPED;
        end
      end
      ST_RUNNING: begin
        if (stop) begin
          state_nxt_s = ST_STOPPED;
        end else begin
          state_nxt_s = ST_RUNNING;
        end
      end
      default: state_nxt_s = ST_STOPPED;
    endcase
  end

  // Free-running prescaler step: advances only while running, wraps on the tick.
  always_comb begin
    if (state_r == ST_RUNNING) begin
      if (tick_s) begin
        presc_step_s = 24'd0;
      end else begin
        presc_step_s = presc_r + 24'd1;
      end
    end else begin
      presc_step_s = presc_r;
    end
  end

  // Time update with priority clear > set_load > tick.
  always_comb begin
    sec0_nxt_s   = sec0_r;
    sec1_nxt_s   = sec1_r;
    min0_nxt_s   = min0_r;
    min1_nxt_s   = min1_r;
    hour_nxt_s   = hour_r;
    presc_nxt_s  = presc_step_s;
    rollover_s   = 1'b0;
    load_err_s   = 1'b0;
    tick_taken_s = 1'b0;
    if (clear) begin
      sec0_nxt_s  = 4'd0;
      sec1_nxt_s  = 4'd0;
      min0_nxt_s  = 4'd0;
      min1_nxt_s  = 4'd0;
      hour_nxt_s  = 5'd0;
      presc_nxt_s = 24'd0;
    end else if (set_load) begin
      // A rejected load still consumes the cycle: any coincident tick is dropped.
      if (time_bcd_ok(set_time)) begin
        hour_nxt_s  = bcd_hour_to_bin(set_time[23:20], set_time[19:16]);
        min1_nxt_s  = set_time[15:12];
        min0_nxt_s  = set_time[11:8];
        sec1_nxt_s  = set_time[7:4];
        sec0_nxt_s  = set_time[3:0];
        presc_nxt_s = 24'd0;
      end else begin
        load_err_s = 1'b1;
      end
    end else if (tick_s) begin
      tick_taken_s = 1'b1;
      if (sec0_r != 4'd9) begin
        sec0_nxt_s = sec0_r + 4'd1;
      end else begin
        sec0_nxt_s = 4'd0;
        if (sec1_r != 4'd5) begin
          sec1_nxt_s = sec1_r + 4'd1;
        end else begin
          sec1_nxt_s = 4'd0;
          if (min0_r != 4'd9) begin
            min0_nxt_s = min0_r + 4'd1;
          end else begin
            min0_nxt_s = 4'd0;
            if (min1_r != 4'd5) begin
              min1_nxt_s = min1_r + 4'd1;
            end else begin
              min1_nxt_s = 4'd0;
              if (hour_r != 5'd23) begin
                hour_nxt_s = hour_r + 5'd1;
              end else begin
                hour_nxt_s = 5'd0;
                rollover_s = 1'b1;
              end
            end
          end
        end
      end
    end else begin
      presc_nxt_s = presc_step_s;
    end
  end

  assign hr_disp_s = hour_display(hour_nxt_s, mode_24h);

`ifdef WATCH_ALARM_EN
  // Alarm hh:mm validity check.
  function automatic logic alarm_bcd_ok(input logic [15:0] a);
    return hour_bcd_ok(a[15:12], a[11:8]) && (a[7:4] <= 4'd5) && (a[3:0] <= 4'd9);
  endfunction

  logic [4:0] alarm_hour_r;
  logic [3:0] alarm_min1_r, alarm_min0_r;
  logic       alarm_ok_s;
  logic       alarm_match_s;
  logic       alarm_hit_r;

  assign alarm_ok_s  = alarm_bcd_ok(alarm_time);
  assign alarm_err_s = alarm_load && !alarm_ok_s;
  // Only a counting tick can fire the alarm; loads and clears landing on hh:mm:00 do not.
  assign alarm_match_s = tick_taken_s && alarm_arm && (hour_nxt_s == alarm_hour_r) &&
                         (min1_nxt_s == alarm_min1_r) && (min0_nxt_s == alarm_min0_r) &&
                         (sec1_nxt_s == 4'd0) && (sec0_nxt_s == 4'd0);

  // Alarm time storage and hit pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hour_r <= 5'd0;
      alarm_min1_r <= 4'd0;
      alarm_min0_r <= 4'd0;
      alarm_hit_r  <= 1'b0;
    end else begin
      if (alarm_load && alarm_ok_s) begin
        alarm_hour_r <= bcd_hour_to_bin(alarm_time[15:12], alarm_time[11:8]);
        alarm_min1_r <= alarm_time[7:4];
        alarm_min0_r <= alarm_time[3:0];
      end else begin
        alarm_hour_r <= alarm_hour_r;
        alarm_min1_r <= alarm_min1_r;
        alarm_min0_r <= alarm_min0_r;
      end
      alarm_hit_r <= alarm_match_s;
    end
  end

  assign alarm_hit = alarm_hit_r;
`else
  assign alarm_err_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_STOPPED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Time, prescaler, display and status pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r   <= 24'd0;
      sec0_r    <= 4'd0;
      sec1_r    <= 4'd0;
      min0_r    <= 4'd0;
      min1_r    <= 4'd0;
      hour_r    <= 5'd0;
      hr1_r     <= HR_RESET[7:4];
      hr0_r     <= HR_RESET[3:0];
      pm_r      <= 1'b0;
      daypass_r <= 1'b0;
      set_err_r <= 1'b0;
    end else begin
      presc_r   <= presc_nxt_s;
      sec0_r    <= sec0_nxt_s;
      sec1_r    <= sec1_nxt_s;
      min0_r    <= min0_nxt_s;
      min1_r    <= min1_nxt_s;
      hour_r    <= hour_nxt_s;
      hr1_r     <= hr_disp_s[7:4];
      hr0_r     <= hr_disp_s[3:0];
      pm_r      <= (hour_nxt_s >= 5'd12);
      daypass_r <= rollover_s;
      set_err_r <= load_err_s | alarm_err_s;
    end
  end

  assign hr1     = hr1_r;
  assign hr0     = hr0_r;
  assign min1    = min1_r;
  assign min0    = min0_r;
  assign sec1    = sec1_r;
  assign sec0    = sec0_r;
  assign pm      = pm_r;
  assign running = (state_r == ST_RUNNING);
  assign daypass = daypass_r;
  assign set_err = set_err_r;

endmodule
